// File: rtl/zle_pkg.sv
// Shared definitions for the zero-length-encoding codec: default widths and
// the decoder FSM state encoding.
package zle_pkg;

  localparam int DW_DEF = 3;
  localparam int CW_DEF = 4;

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_LIT   = 2'd1,
    S_RUN   = 2'd2
  } state_t;

endpackage

// File: rtl/zle_dec_if.sv
// Token-in / symbol-out stream bundle for the zle decoder.
// Handshake: a beat transfers on a rising edge where the sender's valid is 1
// and the receiver's backpressure (i_b / o_b) is 0; i_b=1 / o_b=1 means "not accepting".
interface zle_dec_if #(
  parameter int DW = zle_pkg::DW_DEF,
  parameter int CW = zle_pkg::CW_DEF
);

  logic [CW:0]   i_d;
  logic          i_v;
  logic          i_b;
  logic [DW-1:0] o_d;
  logic          o_v;
  logic          o_b;

  modport master (
    output i_d, i_v, o_b,
    input  i_b, o_d, o_v
  );

  modport slave (
    input  i_d, i_v, o_b,
    output i_b, o_d, o_v
  );

endinterface

// File: rtl/zle_dec_dp.sv
// Decoder datapath: run counter, literal register and the output symbol mux.
module zle_dec_dp
  import zle_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic          clock,
  input  logic          reset,
  input  logic [CW-1:0] tok_len,
  input  logic          load_lit,
  input  logic          load_cnt,
  input  logic          dec_cnt,
  input  logic          lit_sel,
  output logic [DW-1:0] o_d,
  output logic          cnt_eq_1
);

  logic [CW-1:0] cnt_q, cnt_d;
  logic [DW-1:0] lit_q, lit_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_cnt) begin
      cnt_d = tok_len;
    end else if (dec_cnt && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  // Literal bits above DW-1 in the token are deliberately dropped.
  always_comb begin
    lit_d = lit_q;
    if (load_lit) begin
      lit_d = tok_len[DW-1:0];
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
      lit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      lit_q <= lit_d;
    end
  end

  // A run always emits zeros, so only the literal state needs a non-zero mux leg.
  assign o_d      = lit_sel ? lit_q : '0;
  assign cnt_eq_1 = (cnt_q == CW'(1));

endmodule

// File: rtl/zle_dec.sv
// Zero-length-encoding decoder: expands literal tokens to one symbol and run
// tokens to a burst of zero symbols, one token fully drained before the next.
module zle_dec
  import zle_pkg::*;
#(
  parameter int DW = DW_DEF,
  parameter int CW = CW_DEF
) (
  input  logic        clock,
  input  logic        reset,
  zle_dec_if.slave    bus,
  output logic [1:0]  dbg_state
);

  if (DW > CW) begin : g_bad_params
    $error("zle_dec: DW must not exceed CW");
  end

  state_t        state_q, state_d;
  logic          tok_flag;
  logic [CW-1:0] tok_len;
  logic          accept;
  logic          load_lit, load_cnt, dec_cnt, lit_sel;
  logic          cnt_eq_1;

  assign tok_flag = bus.i_d[CW];
  assign tok_len  = bus.i_d[CW-1:0];
  assign accept   = (state_q == S_FETCH) && bus.i_v;

  assign load_lit = accept && !tok_flag;
  assign load_cnt = accept && tok_flag && (tok_len != '0);
  assign dec_cnt  = (state_q == S_RUN) && !bus.o_b;
  assign lit_sel  = (state_q == S_LIT);

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_FETCH: begin
        if (bus.i_v) begin
          if (!tok_flag) begin
            state_d = S_LIT;
          end else if (tok_len != '0) begin
            state_d = S_RUN;
          end
        end
      end
      S_LIT: begin
        if (!bus.o_b) begin
          state_d = S_FETCH;
        end
      end
      S_RUN: begin
        if (!bus.o_b && cnt_eq_1) begin
          state_d = S_FETCH;
        end
      end
      // The unused encoding stalls input for one cycle, then recovers.
      default: state_d = S_FETCH;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_FETCH;
    end else begin
      state_q <= state_d;
    end
  end

  // Outputs decode the state register only; no path from i_v or o_b.
  assign bus.i_b  = (state_q != S_FETCH);
  assign bus.o_v  = (state_q == S_LIT) || (state_q == S_RUN);
  assign dbg_state = state_q;

  zle_dec_dp #(
    .DW(DW),
    .CW(CW)
  ) u_dp (
    .clock    (clock),
    .reset    (reset),
    .tok_len  (tok_len),
    .load_lit (load_lit),
    .load_cnt (load_cnt),
    .dec_cnt  (dec_cnt),
    .lit_sel  (lit_sel),
    .o_d      (bus.o_d),
    .cnt_eq_1 (cnt_eq_1)
  );

endmodule

// File: doc/zle_dec.md
ZLE_DEC -- requirements
Module: zle_dec

Interface
REQ-001 Parameter DW, default 3: literal (decoded symbol) width in bits.
REQ-002 Parameter CW, default 4: run-length field width in bits; the design SHALL require DW <= CW.
REQ-003 clock  input  1  rising-edge clock for all state.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 i_d  input  CW+1  encoded token; bit CW is the run flag, bits CW-1:0 are the run length, and bits DW-1:0 are the literal.
REQ-006 i_v  input  1  input token valid.
REQ-007 i_b  output  1  input backpressure; 1 = not accepting.
REQ-008 o_d  output  DW  decoded symbol.
REQ-009 o_v  output  1  output symbol valid.
REQ-010 o_b  input  1  output backpressure; 1 = consumer not accepting.

Function
REQ-011 A token SHALL transfer on a rising edge where i_v=1 and i_b=0; a symbol SHALL transfer on a rising edge where o_v=1 and o_b=0.
REQ-012 The FSM SHALL have exactly three states: FETCH, LIT and RUN.
REQ-013 FETCH: i_b=0, o_v=0; with i_v=0 it SHALL stay in FETCH.
REQ-014 FETCH with i_v=1 and flag=0: latch i_d[DW-1:0] into the literal register and go to LIT; literal bits above DW-1 are ignored.
REQ-015 FETCH with i_v=1, flag=1 and length!=0: load the counter with the length and go to RUN.
REQ-016 FETCH with i_v=1, flag=1 and length=0: consume the token, emit nothing, stay in FETCH.
REQ-017 LIT: i_b=1, o_v=1, o_d=literal; on o_b=0 go to FETCH, on o_b=1 hold all state.
REQ-018 RUN: i_b=1, o_v=1, o_d=0; on o_b=0 decrement the counter, and if the counter was 1 go to FETCH; on o_b=1 hold all state.
REQ-019 When o_v=0, o_d SHALL be driven to 0.
REQ-020 i_b, o_v and o_d SHALL be pure decodes of state and registers, with no combinational path from i_v or o_b to them.
REQ-021 Latency: the first symbol SHALL be valid in the cycle after token acceptance.
REQ-022 Throughput: a literal SHALL take 2 cycles; a run of length L SHALL take L+1 cycles when o_b=0.
REQ-023 The maximum run length SHALL be 2^CW-1 (15 at default); the counter SHALL never wrap or underflow.
REQ-024 Output of a token SHALL complete in order before the next token is accepted.
REQ-025 Decode SHALL invert the zle encoder: a literal v maps to v, and a run token {1,n} maps to n zeros, including saturated-run tokens followed by {1,0}.

Reset
REQ-026 On reset low the block SHALL immediately enter FETCH with counter=0 and literal register=0, giving outputs i_b=0, o_v=0, o_d=0.
REQ-027 Reset asserted mid-LIT or mid-RUN SHALL abort the token; the remaining symbols SHALL be discarded and never emitted.
REQ-028 The first token SHALL be accepted on the first rising edge after reset deassertion with i_v=1.

Structure
REQ-029 The state encodings (FETCH=2'd0, LIT=2'd1, RUN=2'd2) and the DW/CW defaults SHALL live in the shared zle package.
REQ-030 The block SHALL be split into an FSM (zle_dec top) and one sub-module, zle_dec_dp, which holds the counter, the literal register and the o_d mux and returns a cnt_eq_1 flag to the FSM.
REQ-031 State value 2'd3 SHALL behave as FETCH with outputs i_b=1 and o_v=0, then return to FETCH on the next edge.

Verification
REQ-032 Literal: token 5'b00101 with o_b=0 -> one symbol 3'd5, o_v high for exactly 1 cycle, i_b low again 2 cycles after acceptance.
REQ-033 Run: token 5'b10011 with o_b=0 -> exactly three symbols 3'd0 on consecutive cycles, then FETCH.
REQ-034 Zero-length run: tokens 5'b10000 then 5'b00010 -> only 3'd2 is emitted, and the 5'b10000 token consumes 1 cycle.
REQ-035 Backpressure: token 5'b10010 with o_b=1 for 4 cycles then 0 -> o_v held high and counter held, then 2 zeros emitted; no token accepted meanwhile.
REQ-036 Reset mid-run: token 5'b11111, reset pulsed low after 5 zeros -> o_v=0 and i_b=0 immediately, and no further zeros are emitted.
REQ-037 Round trip: random 3-bit stream -> zle encoder -> zle_dec with random o_b and i_v -> output identical to the source stream.
